// File: rtl/multicycle_ctrl_param_if.sv
// rtl/multicycle_ctrl_param_if.sv - controller <-> datapath signal bundle
// master = controller side, slave = datapath side.
interface multicycle_ctrl_param_if #(
  parameter int OPC_W    = 4,
  parameter int RSEL_W   = 3,
  parameter int NUM_REGS = 8
);
  logic                      run;
  logic                      mem_ready;
  logic [OPC_W+2*RSEL_W-1:0] IR;
  logic                      G_or;
  logic                      IR_in;
  logic                      ADDR_in;
  logic                      DOUT_in;
  logic                      W_D;
  logic                      G_in;
  logic                      A_in;
  logic                      incr_PC;
  logic [1:0]                mux_control;
  logic [OPC_W-1:0]          ULA_control;
  logic [NUM_REGS-1:0]       register_in;
  logic [RSEL_W-1:0]         register_out;
  logic                      done;
  logic                      illegal;

  modport master (
    input  run, mem_ready, IR, G_or,
    output IR_in, ADDR_in, DOUT_in, W_D, G_in, A_in, incr_PC,
           mux_control, ULA_control, register_in, register_out, done, illegal
  );

  modport slave (
    output run, mem_ready, IR, G_or,
    input  IR_in, ADDR_in, DOUT_in, W_D, G_in, A_in, incr_PC,
           mux_control, ULA_control, register_in, register_out, done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_param.sv
// rtl/multicycle_ctrl_param.sv - parametrised multi-cycle processor control FSM
// Mealy decode of step + IR; memory steps wait on mem_ready, run=0 freezes.
module multicycle_ctrl_param #(
  parameter int OPC_W    = 4,
  parameter int RSEL_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_ctrl_param_if.master bus
);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MVNZ = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_MV   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_MVI  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SRL  = OPC_W'(10);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} state_t;

  state_t state, state_next;

  logic [OPC_W-1:0]  opcode;
  logic [RSEL_W-1:0] rx, ry;
  logic is_alu, is_ldst, is_mem_op, is_mv, is_ill;
  logic active, mem_step, step_go;

  logic                ir_in, addr_in, dout_in, w_d, g_in, a_in, incr_pc;
  logic [1:0]          mux;
  logic [OPC_W-1:0]    ula;
  logic [NUM_REGS-1:0] reg_in;
  logic [RSEL_W-1:0]   reg_out;
  logic                done, illegal, write_rx;

  assign opcode    = bus.IR[OPC_W+2*RSEL_W-1 -: OPC_W];
  assign rx        = bus.IR[2*RSEL_W-1 -: RSEL_W];
  assign ry        = bus.IR[RSEL_W-1:0];
  assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_SRL);
  assign is_ldst   = (opcode == OP_LD) || (opcode == OP_ST);
  assign is_mem_op = is_ldst || (opcode == OP_MVI);
  assign is_mv     = (opcode == OP_MV) || (opcode == OP_MVNZ);
  assign is_ill    = opcode > OP_SRL;

  assign active   = !reset && bus.run;
  assign mem_step = (state == T0) || ((state == T2) && is_mem_op);
  assign step_go  = !mem_step || bus.mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= T0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (active && step_go) begin
      case (state)
        T0:      state_next = T1;
        T1:      state_next = is_ill ? T4 : T2;
        T2:      state_next = is_mv ? T0 : T3;
        T3:      state_next = is_alu ? T4 : T0;
        default: state_next = T0;
      endcase
    end
  end

  always_comb begin
    ir_in    = 1'b0;
    addr_in  = 1'b0;
    dout_in  = 1'b0;
    w_d      = 1'b0;
    g_in     = 1'b0;
    a_in     = 1'b0;
    incr_pc  = 1'b0;
    mux      = 2'b00;
    ula      = '0;
    reg_out  = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    write_rx = 1'b0;
    if (active) begin
      case (state)
        T0: begin
          ir_in   = bus.mem_ready;
          incr_pc = bus.mem_ready;
        end
        T1: begin
          if (is_alu) begin
            mux = 2'b01; reg_out = rx; a_in = 1'b1;
          end else if (is_ldst) begin
            mux = 2'b01; reg_out = ry; addr_in = 1'b1;
          end else if (is_mv) begin
            mux = 2'b01; reg_out = ry;
            write_rx = (opcode == OP_MV) || bus.G_or;
          end else if (opcode == OP_MVI) begin
            mux = 2'b10; addr_in = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        T2: begin
          if (is_alu) begin
            mux = 2'b01; reg_out = ry; ula = opcode; g_in = 1'b1;
          end else if ((opcode == OP_LD) || (opcode == OP_MVI)) begin
            // memory data on DIN; the write waits for mem_ready
            mux      = 2'b00;
            write_rx = bus.mem_ready;
            incr_pc  = (opcode == OP_MVI) && bus.mem_ready;
          end else if (opcode == OP_ST) begin
            mux = 2'b01; reg_out = rx;
            dout_in = bus.mem_ready; w_d = bus.mem_ready;
          end else if (is_mv) begin
            mux = 2'b10; addr_in = 1'b1; done = 1'b1;
          end
        end
        T3: begin
          if (is_alu) begin
            mux = 2'b11; write_rx = 1'b1;
          end else if (is_mem_op) begin
            mux = 2'b10; addr_in = 1'b1; done = 1'b1;
          end
        end
        default: begin
          mux = 2'b10; addr_in = 1'b1; done = 1'b1;
        end
      endcase
    end
    // Rx beyond the register file selects nothing rather than wrapping
    for (int i = 0; i < NUM_REGS; i++) reg_in[i] = write_rx && (rx == RSEL_W'(i));
  end

  assign bus.IR_in        = ir_in;
  assign bus.ADDR_in      = addr_in;
  assign bus.DOUT_in      = dout_in;
  assign bus.W_D          = w_d;
  assign bus.G_in         = g_in;
  assign bus.A_in         = a_in;
  assign bus.incr_PC      = incr_pc;
  assign bus.mux_control  = mux;
  assign bus.ULA_control  = ula;
  assign bus.register_in  = reg_in;
  assign bus.register_out = reg_out;
  assign bus.done         = done;
  assign bus.illegal      = illegal;
endmodule

// File: tb/tb_multicycle_ctrl_param.sv
// tb/tb_multicycle_ctrl_param.sv - bench for multicycle_ctrl_param
// NUM_REGS=6 so that R6/R7 exercise the suppressed-write case.
module tb_multicycle_ctrl_param;
  localparam int NR = 6;

  typedef struct packed {
    logic          ir_in, addr_in, dout_in, w_d, g_in, a_in, incr_pc;
    logic [1:0]    mux;
    logic [3:0]    ula;
    logic [NR-1:0] reg_in;
    logic [2:0]    reg_out;
    logic          done, illegal;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  obs_t obs;

  multicycle_ctrl_param_if #(.OPC_W(4), .RSEL_W(3), .NUM_REGS(NR)) bus ();

  multicycle_ctrl_param #(.OPC_W(4), .RSEL_W(3), .NUM_REGS(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign obs = {bus.IR_in, bus.ADDR_in, bus.DOUT_in, bus.W_D, bus.G_in, bus.A_in, bus.incr_PC,
                bus.mux_control, bus.ULA_control, bus.register_in, bus.register_out,
                bus.done, bus.illegal};

  function automatic bit is_alu(int opc);
    return (opc >= 5) && (opc <= 10);
  endfunction

  function automatic bit is_mem_step(int opc, int step);
    return (step == 0) || ((step == 2) && (opc == 0 || opc == 1 || opc == 4));
  endfunction

  function automatic int n_steps(int opc);
    if (opc == 2 || opc == 3) return 3;
    if (opc <= 4)             return 4;
    if (is_alu(opc))          return 5;
    return 3;
  endfunction

  function automatic int step_at(int opc, int k);
    if (opc > 10 && k == 2) return 4;
    return k;
  endfunction

  // Expected outputs for one cycle, straight from the per-step instruction table
  function automatic obs_t exp_out(logic [9:0] ir, int step, logic g, logic mr, logic rn);
    obs_t          e;
    int            opc;
    logic [2:0]    rx, ry;
    logic [NR-1:0] oh;
    logic          go;
    e   = '0;
    opc = int'(ir[9:6]);
    rx  = ir[5:3];
    ry  = ir[2:0];
    oh  = (int'(rx) < NR) ? (NR'(1) << rx) : '0;
    go  = is_mem_step(opc, step) ? mr : 1'b1;
    if (!rn) return e;
    case (step)
      0: begin e.ir_in = go; e.incr_pc = go; end
      1: begin
        if (is_alu(opc))  begin e.mux = 2'd1; e.reg_out = rx; e.a_in = 1'b1; end
        else if (opc <= 1) begin e.mux = 2'd1; e.reg_out = ry; e.addr_in = 1'b1; end
        else if (opc <= 3) begin e.mux = 2'd1; e.reg_out = ry; if (opc == 3 || g) e.reg_in = oh; end
        else if (opc == 4) begin e.mux = 2'd2; e.addr_in = 1'b1; end
        else e.illegal = 1'b1;
      end
      2: begin
        if (is_alu(opc)) begin e.mux = 2'd1; e.reg_out = ry; e.ula = ir[9:6]; e.g_in = 1'b1; end
        else if (opc == 0 || opc == 4) begin e.reg_in = go ? oh : '0; e.incr_pc = (opc == 4) && go; end
        else if (opc == 1) begin e.mux = 2'd1; e.reg_out = rx; e.dout_in = go; e.w_d = go; end
        else begin e.mux = 2'd2; e.addr_in = 1'b1; e.done = 1'b1; end
      end
      3: begin
        if (is_alu(opc)) begin e.mux = 2'd3; e.reg_in = oh; end
        else begin e.mux = 2'd2; e.addr_in = 1'b1; e.done = 1'b1; end
      end
      default: begin e.mux = 2'd2; e.addr_in = 1'b1; e.done = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic cyc(input logic r, input logic m, input logic [9:0] ir, input logic g);
    @(posedge clock);
    #1;
    bus.run = r; bus.mem_ready = m; bus.IR = ir; bus.G_or = g;
    @(negedge clock);
  endtask

  task automatic test_reset;
    logic [9:0] ir;
    ir = {4'd3, 3'd2, 3'd1};
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.IR = ir; bus.G_or = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_idle: got %h expected 0", obs); end
    @(posedge clock); #1; reset = 1'b0; bus.run = 1'b0;
    @(negedge clock);
    checks++; if (obs !== '0) begin errors++; $display("FAIL run_low_idle: got %h expected 0", obs); end
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.ir_in && obs.incr_pc && !obs.done)) begin errors++; $display("FAIL reset_t0: ir_in=%0b incr_pc=%0b expected 1/1", obs.ir_in, obs.incr_pc); end
    cyc(1, 1, ir, 0);
    checks++; if (obs.reg_in !== 6'h04 || obs.reg_out !== 3'd1) begin errors++; $display("FAIL mv_t1: reg_in=%h reg_out=%0d expected 04/1", obs.reg_in, obs.reg_out); end
    cyc(1, 1, ir, 0);
    checks++; if (obs.done !== 1'b1) begin errors++; $display("FAIL mv_done: done=%0b expected 1", obs.done); end
  endtask

  task automatic test_add;
    logic [9:0] ir;
    ir = {4'd5, 3'd1, 3'd2};
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.ir_in && obs.incr_pc)) begin errors++; $display("FAIL add_t0: ir_in=%0b incr_pc=%0b expected 1/1", obs.ir_in, obs.incr_pc); end
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.a_in && obs.reg_out == 3'd1 && obs.mux == 2'd1)) begin errors++; $display("FAIL add_t1: a_in=%0b sel=%0d mux=%0d expected 1/1/1", obs.a_in, obs.reg_out, obs.mux); end
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.g_in && obs.ula == 4'd5 && obs.reg_out == 3'd2)) begin errors++; $display("FAIL add_t2: g_in=%0b ula=%0d sel=%0d expected 1/5/2", obs.g_in, obs.ula, obs.reg_out); end
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.reg_in == 6'h02 && obs.mux == 2'd3 && !obs.done)) begin errors++; $display("FAIL add_t3: reg_in=%h mux=%0d done=%0b expected 02/3/0", obs.reg_in, obs.mux, obs.done); end
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.done && obs.addr_in && obs.mux == 2'd2)) begin errors++; $display("FAIL add_t4: done=%0b addr_in=%0b mux=%0d expected 1/1/2", obs.done, obs.addr_in, obs.mux); end
  endtask

  task automatic test_ld_wait;
    logic [9:0] ir;
    ir = {4'd0, 3'd3, 3'd4};
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.addr_in && obs.reg_out == 3'd4)) begin errors++; $display("FAIL ld_t1: addr_in=%0b sel=%0d expected 1/4", obs.addr_in, obs.reg_out); end
    for (int w = 0; w < 2; w++) begin
      cyc(1, 0, ir, 0);
      checks++; if (obs.reg_in !== '0 || obs.done !== 1'b0) begin errors++; $display("FAIL ld_wait%0d: reg_in=%h done=%0b expected 00/0", w, obs.reg_in, obs.done); end
    end
    cyc(1, 1, ir, 0);
    checks++; if (obs.reg_in !== 6'h08 || obs.mux !== 2'd0) begin errors++; $display("FAIL ld_write: reg_in=%h mux=%0d expected 08/0", obs.reg_in, obs.mux); end
    cyc(1, 1, ir, 0);
    checks++; if (obs.done !== 1'b1) begin errors++; $display("FAIL ld_done: done=%0b expected 1", obs.done); end
  endtask

  task automatic test_mvnz;
    logic [9:0] ir;
    ir = {4'd2, 3'd0, 3'd5};
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    checks++; if (obs.reg_in !== '0) begin errors++; $display("FAIL mvnz_g0: reg_in=%h expected 00", obs.reg_in); end
    cyc(1, 1, ir, 0);
    checks++; if (obs.done !== 1'b1) begin errors++; $display("FAIL mvnz_g0_done: done=%0b expected 1", obs.done); end
    cyc(1, 1, ir, 1);
    cyc(1, 1, ir, 1);
    checks++; if (obs.reg_in !== 6'h01 || obs.reg_out !== 3'd5) begin errors++; $display("FAIL mvnz_g1: reg_in=%h sel=%0d expected 01/5", obs.reg_in, obs.reg_out); end
    cyc(1, 1, ir, 1);
    checks++; if (obs.done !== 1'b1) begin errors++; $display("FAIL mvnz_g1_done: done=%0b expected 1", obs.done); end
  endtask

  task automatic test_mvi_stall;
    logic [9:0]    ir;
    logic [9:0]    inc_mask;
    logic [NR-1:0] wr;
    logic [1:0]    mr_seq [10];
    ir = {4'd4, 3'd7, 3'd0};
    mr_seq = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    inc_mask = '0;
    wr = '0;
    for (int c = 0; c < 10; c++) begin
      cyc(1, mr_seq[c][0], ir, 0);
      inc_mask[c] = obs.incr_pc;
      wr = wr | obs.reg_in;
      if (c == 9) begin
        checks++; if (obs.done !== 1'b1) begin errors++; $display("FAIL mvi_done: done=%0b expected 1", obs.done); end
      end
    end
    checks++; if (inc_mask !== 10'b01_0000_1000) begin errors++; $display("FAIL mvi_incr: mask=%b expected 0100001000", inc_mask); end
    checks++; if (wr !== '0) begin errors++; $display("FAIL mvi_r7_write: reg_in=%h expected 00", wr); end
  endtask

  task automatic test_illegal_run;
    logic [9:0] ir;
    ir = {4'hF, 3'd1, 3'd2};
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.illegal && obs.reg_in == '0 && !obs.w_d && !obs.dout_in)) begin errors++; $display("FAIL ill_t1: illegal=%0b reg_in=%h w_d=%0b expected 1/00/0", obs.illegal, obs.reg_in, obs.w_d); end
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.done && !obs.illegal && obs.reg_in == '0)) begin errors++; $display("FAIL ill_t4: done=%0b illegal=%0b expected 1/0", obs.done, obs.illegal); end
    ir = {4'd5, 3'd3, 3'd1};
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    for (int w = 0; w < 4; w++) begin
      cyc(0, 1, ir, 0);
      checks++; if (obs !== '0) begin errors++; $display("FAIL run_hold%0d: got %h expected 0", w, obs); end
    end
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.g_in && obs.ula == 4'd5 && obs.reg_out == 3'd1)) begin errors++; $display("FAIL run_resume_t2: g_in=%0b ula=%0d sel=%0d expected 1/5/1", obs.g_in, obs.ula, obs.reg_out); end
    cyc(1, 1, ir, 0);
    checks++; if (obs.reg_in !== 6'h08) begin errors++; $display("FAIL run_resume_t3: reg_in=%h expected 08", obs.reg_in); end
    cyc(1, 1, ir, 0);
    checks++; if (obs.done !== 1'b1) begin errors++; $display("FAIL run_resume_t4: done=%0b expected 1", obs.done); end
  endtask

  task automatic test_reset_mid;
    logic [9:0] ir;
    ir = {4'd1, 3'd2, 3'd3};
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    checks++; if (!(obs.w_d && obs.dout_in && obs.reg_out == 3'd2)) begin errors++; $display("FAIL st_t2: w_d=%0b dout_in=%0b sel=%0d expected 1/1/2", obs.w_d, obs.dout_in, obs.reg_out); end
    @(posedge clock); #1; reset = 1'b1; #1;
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_mid_now: got %h expected 0", obs); end
    @(negedge clock);
    checks++; if (obs !== '0) begin errors++; $display("FAIL reset_mid_hold: got %h expected 0", obs); end
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    checks++; if (!(obs.ir_in && !obs.done && !obs.addr_in)) begin errors++; $display("FAIL reset_mid_t0: ir_in=%0b done=%0b expected 1/0", obs.ir_in, obs.done); end
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    cyc(1, 1, ir, 0);
    checks++; if (obs.done !== 1'b1) begin errors++; $display("FAIL st_done: done=%0b expected 1", obs.done); end
  endtask

  task automatic test_random;
    logic [9:0] ir;
    logic       r, m, g, adv;
    obs_t       e;
    int         opc, st, guard;
    for (int n = 0; n < 60; n++) begin
      ir  = 10'($urandom);
      opc = int'(ir[9:6]);
      for (int k = 0; k < n_steps(opc); k++) begin
        st    = step_at(opc, k);
        guard = 0;
        adv   = 1'b0;
        while (!adv && guard < 40) begin
          r = ($urandom_range(0, 7) != 0);
          m = ($urandom_range(0, 2) != 0);
          g = 1'($urandom);
          cyc(r, m, ir, g);
          e = exp_out(ir, st, g, m, r);
          checks++; if (obs !== e) begin errors++; $display("FAIL rand_i%0d_s%0d: got %h expected %h", n, st, obs, e); end
          adv = r && (!is_mem_step(opc, st) || m);
          guard++;
        end
        if (!adv) begin
          errors++;
          $display("FAIL rand_timeout: instr %0d step %0d never advanced, expected advance", n, st);
        end
      end
    end
  endtask

  initial begin
    bus.run = 1'b0; bus.mem_ready = 1'b0; bus.IR = '0; bus.G_or = 1'b0;
    test_reset;
    test_add;
    test_ld_wait;
    test_mvnz;
    test_mvi_stall;
    test_illegal_run;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
